// File: rtl/board_frame_painter.sv
`default_nettype none
// ============================================================================
// Module      : board_frame_painter
// Description : Paints a BOARD_W x BOARD_H board into video RAM, one pixel per
//               cycle, with a pointer-cell border and per-status cell colours.
// Revision    : 1.0 - initial release
// ============================================================================
module board_frame_painter #(
    parameter int BOARD_W     = 16,
    parameter int BOARD_H     = 16,
    parameter int CELL_W      = 7,
    parameter int CELL_H      = 7,
    parameter int STATUS_BITS = 2,
    parameter int COLOR_BITS  = 3,
    parameter int ADDR_BITS   = 14,
    parameter int PTR_BITS    = 4,
    parameter logic [COLOR_BITS-1:0] COL_EMPTY = 3'b111,
    parameter logic [COLOR_BITS-1:0] COL_BLACK = 3'b000,
    parameter logic [COLOR_BITS-1:0] COL_BLUE  = 3'b001,
    parameter logic [COLOR_BITS-1:0] COL_WIN   = 3'b110,
    parameter logic [COLOR_BITS-1:0] COL_PTR   = 3'b100
) (
    input  logic                                   Clck,
    input  logic                                   Reset,
    input  logic                                   in_cont_signal,
    input  logic                                   next_out_cont_signal,
    input  logic [BOARD_W*BOARD_H*STATUS_BITS-1:0] board,
    input  logic [PTR_BITS-1:0]                    pointer_x,
    input  logic [PTR_BITS-1:0]                    pointer_y,
    output logic [ADDR_BITS-1:0]                   mem_addr,
    output logic [COLOR_BITS-1:0]                  mem_data,
    output logic                                   mem_wren,
    output logic                                   out_cont_signal,
    output logic                                   busy
);

    localparam int BB    = BOARD_W * BOARD_H * STATUS_BITS;
    localparam int SCR_W = BOARD_W * CELL_W;
    localparam int CX_W  = (BOARD_W > 1) ? $clog2(BOARD_W) : 1;
    localparam int CY_W  = (BOARD_H > 1) ? $clog2(BOARD_H) : 1;
    localparam int PX_W  = (CELL_W  > 1) ? $clog2(CELL_W)  : 1;
    localparam int PY_W  = (CELL_H  > 1) ? $clog2(CELL_H)  : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [BB-1:0]         board_q, board_d;
    logic [PTR_BITS-1:0]   ptr_x_q, ptr_x_d, ptr_y_q, ptr_y_d;
    logic [CX_W-1:0]       cx_q, cx_d;
    logic [CY_W-1:0]       cy_q, cy_d;
    logic [PX_W-1:0]       px_q, px_d;
    logic [PY_W-1:0]       py_q, py_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [COLOR_BITS-1:0] data_q, data_d;
    logic                  wren_q, wren_d;
    logic                  done_q, done_d;

    logic                  last_px, last_py, last_cx, last_cy, cell_end, frame_end;
    logic [CX_W-1:0]       nx_cx;
    logic [CY_W-1:0]       nx_cy;
    logic [PX_W-1:0]       nx_px;
    logic [PY_W-1:0]       nx_py;
    logic [BB-1:0]         src_board, shifted;
    logic [PTR_BITS-1:0]   src_ptr_x, src_ptr_y;
    logic [STATUS_BITS-1:0] status;
    logic                  on_border, in_ptr_cell;
    logic [31:0]           full_addr;
    logic [COLOR_BITS-1:0] pix_colour;

    // State register and all datapath registers
    always_ff @(posedge Clck) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            board_q <= '0;
            ptr_x_q <= '0;
            ptr_y_q <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            px_q    <= '0;
            py_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            ptr_x_q <= ptr_x_d;
            ptr_y_q <= ptr_y_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            px_q    <= px_d;
            py_q    <= py_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
            done_q  <= done_d;
        end
    end

    assign last_px   = (px_q == PX_W'(CELL_W - 1));
    assign last_py   = (py_q == PY_W'(CELL_H - 1));
    assign last_cx   = (cx_q == CX_W'(BOARD_W - 1));
    assign last_cy   = (cy_q == CY_W'(BOARD_H - 1));
    assign cell_end  = last_px && last_py;
    assign frame_end = cell_end && last_cx && last_cy;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_cont_signal)       state_d = S_FILL;
            S_FILL:  if (frame_end)            state_d = S_DONE;
            S_DONE:  if (next_out_cont_signal) state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
    end

    // Position of the pixel to be presented after the coming edge
    always_comb begin
        if (state_q == S_IDLE) begin
            nx_px = '0;
            nx_py = '0;
            nx_cx = '0;
            nx_cy = '0;
        end else begin
            nx_px = last_px ? '0 : px_q + PX_W'(1);
            nx_py = last_px ? (last_py ? '0 : py_q + PY_W'(1)) : py_q;
            nx_cx = cell_end ? (last_cx ? '0 : cx_q + CX_W'(1)) : cx_q;
            nx_cy = (cell_end && last_cx) ? (last_cy ? '0 : cy_q + CY_W'(1)) : cy_q;
        end
    end

    // The first pixel is coloured straight from the inputs being latched
    assign src_board = (state_q == S_IDLE) ? board     : board_q;
    assign src_ptr_x = (state_q == S_IDLE) ? pointer_x : ptr_x_q;
    assign src_ptr_y = (state_q == S_IDLE) ? pointer_y : ptr_y_q;

    always_comb begin
        shifted     = src_board >> ((int'(nx_cy) * BOARD_W + int'(nx_cx)) * STATUS_BITS);
        status      = shifted[STATUS_BITS-1:0];
        on_border   = (nx_px == '0) || (nx_px == PX_W'(CELL_W - 1)) ||
                      (nx_py == '0) || (nx_py == PY_W'(CELL_H - 1));
        in_ptr_cell = (int'(nx_cx) == int'(src_ptr_x)) && (int'(nx_cy) == int'(src_ptr_y));
        full_addr   = 32'(int'(nx_cx) * CELL_W + int'(nx_px) +
                          (int'(nx_cy) * CELL_H + int'(nx_py)) * SCR_W);
        if (in_ptr_cell && on_border)
            pix_colour = COL_PTR;
        else if (status == STATUS_BITS'(1))
            pix_colour = COL_BLACK;
        else if (status == STATUS_BITS'(2))
            pix_colour = COL_BLUE;
        else if (status == STATUS_BITS'(3))
            pix_colour = COL_WIN;
        else
            pix_colour = COL_EMPTY;
    end

    always_comb begin
        board_d = board_q;
        ptr_x_d = ptr_x_q;
        ptr_y_d = ptr_y_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        px_d    = px_q;
        py_d    = py_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wren_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_cont_signal) begin
                    board_d = board;
                    ptr_x_d = pointer_x;
                    ptr_y_d = pointer_y;
                    cx_d    = nx_cx;
                    cy_d    = nx_cy;
                    px_d    = nx_px;
                    py_d    = nx_py;
                    addr_d  = ADDR_BITS'(full_addr);
                    data_d  = pix_colour;
                    wren_d  = 1'b1;
                end
            end
            S_FILL: begin
                if (frame_end) begin
                    done_d = 1'b1;
                end else begin
                    cx_d   = nx_cx;
                    cy_d   = nx_cy;
                    px_d   = nx_px;
                    py_d   = nx_py;
                    addr_d = ADDR_BITS'(full_addr);
                    data_d = pix_colour;
                    wren_d = 1'b1;
                end
            end
            S_DONE: begin
                done_d = !next_out_cont_signal;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    assign mem_addr        = addr_q;
    assign mem_data        = data_q;
    assign mem_wren        = wren_q;
    assign out_cont_signal = done_q;
    assign busy            = (state_q == S_FILL);

endmodule
`default_nettype wire

// File: tb/tb_board_frame_painter.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_frame_painter
// Description : Directed, table-driven bench for board_frame_painter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_frame_painter;

    logic       clk;
    logic       rst_n;
    logic       in_cont, next_out;
    logic [7:0] brd;
    logic       ptr_x, ptr_y;
    logic [3:0] mem_addr;
    logic [2:0] mem_data;
    logic       mem_wren, out_cont, busy;

    logic         b_start, b_next;
    logic [511:0] b_board;
    logic [3:0]   b_px, b_py;
    logic [13:0]  b_addr;
    logic [2:0]   b_data;
    logic         b_wren, b_out_cont, b_busy;

    int n_cmp = 0;
    int n_bad = 0;

    board_frame_painter #(
        .BOARD_W(2), .BOARD_H(2), .CELL_W(2), .CELL_H(2),
        .ADDR_BITS(4), .PTR_BITS(1)
    ) u_small (
        .Clck(clk), .Reset(rst_n),
        .in_cont_signal(in_cont), .next_out_cont_signal(next_out),
        .board(brd), .pointer_x(ptr_x), .pointer_y(ptr_y),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
        .out_cont_signal(out_cont), .busy(busy)
    );

    board_frame_painter u_big (
        .Clck(clk), .Reset(rst_n),
        .in_cont_signal(b_start), .next_out_cont_signal(b_next),
        .board(b_board), .pointer_x(b_px), .pointer_y(b_py),
        .mem_addr(b_addr), .mem_data(b_data), .mem_wren(b_wren),
        .out_cont_signal(b_out_cont), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [7:0]      board;
        logic            px;
        logic            py;
        logic [3:0][2:0] exp;   // colour per cell index cy*2+cx (all 2x2 pixels are border)
    } vec_t;

    vec_t vecs[4];
    int   order[16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_frame(input vec_t v, input int chg_at, input int rst_at);
        brd   = v.board;
        ptr_x = v.px;
        ptr_y = v.py;
        @(negedge clk);
        in_cont = 1'b1;
        @(negedge clk);
        in_cont = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            chk({v.name, "/wren"}, int'(mem_wren), 1);
            chk({v.name, "/addr"}, int'(mem_addr), order[i]);
            chk({v.name, "/data"}, int'(mem_data), int'(v.exp[i/4]));
            if (i == 0 || i == 15) chk({v.name, "/busy"}, int'(busy), 1);
            if (i == chg_at) brd = ~v.board;
            if (i == rst_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                chk({v.name, "/rst_wren"}, int'(mem_wren), 0);
                chk({v.name, "/rst_out_cont"}, int'(out_cont), 0);
                chk({v.name, "/rst_busy"}, int'(busy), 0);
                rst_n = 1'b1;
                return;
            end
        end
        @(negedge clk);
        chk({v.name, "/done_out_cont"}, int'(out_cont), 1);
        chk({v.name, "/done_wren"}, int'(mem_wren), 0);
        chk({v.name, "/done_busy"}, int'(busy), 0);
    endtask

    task automatic release_done(input string name, input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, "/hold_out_cont"}, int'(out_cont), 1);
            chk({name, "/hold_wren"}, int'(mem_wren), 0);
        end
        next_out = 1'b1;
        @(negedge clk);
        next_out = 1'b0;
        chk({name, "/release"}, int'(out_cont), 0);
    endtask

    initial begin
        int  cnt;
        int  last_a, last_d, first_d;
        bit  seen;

        vecs[0] = '{"empty_p11", 8'b00_00_00_00, 1'b1, 1'b1, {3'b100, 3'b111, 3'b111, 3'b111}};
        vecs[1] = '{"status_p00", 8'b11_10_01_00, 1'b0, 1'b0, {3'b110, 3'b001, 3'b000, 3'b100}};
        vecs[2] = '{"rev_p10", 8'b00_01_10_11, 1'b1, 1'b0, {3'b111, 3'b000, 3'b100, 3'b110}};
        vecs[3] = '{"blue_p01", 8'b10_10_10_10, 1'b0, 1'b1, {3'b001, 3'b100, 3'b001, 3'b001}};

        rst_n = 1'b0; in_cont = 1'b0; next_out = 1'b0;
        brd = '0; ptr_x = 1'b0; ptr_y = 1'b0;
        b_start = 1'b0; b_next = 1'b0; b_board = '0; b_px = 4'd15; b_py = 4'd15;
        repeat (3) @(negedge clk);
        chk("reset/wren", int'(mem_wren), 0);
        chk("reset/out_cont", int'(out_cont), 0);
        chk("reset/busy", int'(busy), 0);
        chk("reset/addr", int'(mem_addr), 0);
        chk("reset/data", int'(mem_data), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            do_frame(vecs[k], -1, -1);
            release_done(vecs[k].name, 2);
        end

        // Board changes mid-frame must not leak into the frame
        do_frame(vecs[1], 4, -1);
        release_done("snapshot", 1);

        // Long DONE hold with start asserted, then simultaneous start+release
        do_frame(vecs[0], -1, -1);
        in_cont = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold10/out_cont", int'(out_cont), 1);
            chk("hold10/wren", int'(mem_wren), 0);
        end
        next_out = 1'b1;
        @(negedge clk);
        in_cont  = 1'b0;
        next_out = 1'b0;
        chk("both_high/out_cont", int'(out_cont), 0);
        chk("both_high/wren", int'(mem_wren), 0);
        @(negedge clk);
        chk("both_high/idle_wren", int'(mem_wren), 0);
        chk("both_high/idle_busy", int'(busy), 0);
        do_frame(vecs[2], -1, -1);
        release_done("second_frame", 0);

        // Reset during the seventh write, then a clean frame
        do_frame(vecs[0], -1, 6);
        @(negedge clk);
        chk("after_rst/wren", int'(mem_wren), 0);
        do_frame(vecs[3], -1, -1);
        release_done("after_rst", 0);

        // Full-size instance
        cnt = 0; last_a = -1; last_d = -1; first_d = -1; seen = 1'b0;
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int c = 0; c < 13000 && !seen; c++) begin
            if (c > 0) @(negedge clk);
            if (b_out_cont) begin
                seen = 1'b1;
                chk("big/done_wren", int'(b_wren), 0);
            end else if (b_wren) begin
                if (cnt == 0) begin
                    chk("big/first_addr", int'(b_addr), 0);
                    first_d = int'(b_data);
                end
                cnt++;
                last_a = int'(b_addr);
                last_d = int'(b_data);
            end
        end
        chk("big/done_seen", int'(seen), 1);
        chk("big/count", cnt, 12544);
        chk("big/last_addr", last_a, 12543);
        chk("big/last_data", last_d, 4);
        chk("big/first_data", first_d, 7);
        b_next = 1'b1;
        @(negedge clk);
        b_next = 1'b0;
        chk("big/release", int'(b_out_cont), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
